p_out_stage: RTL and testbench
==============================

# p_out_stage

Output end of the DSP slice datapath, mirroring the A/D input pre-adder stage at the other end of the pipe. Takes the 48-bit ALU result, optionally registers it as P, drives the P/carry/multsign cascade outputs, and runs the pattern detector. The detector produces match, inverse-match, overflow and underflow flags, plus optional auto-reset of the P register.

## Interface
Parameters:
- PREG, 1 — 1: P and flag registers present; 0: P path combinational, history logic disabled
- USE_PATTERN_DETECT, "NO_PATDET" — "PATDET" enables the detector; otherwise all four flags are held 0
- PATTERN, 48'h0 — static pattern
- MASK, 48'h3FFF_FFFF_FFFF — static mask; bit=1 ignores that bit in the compare
- SEL_PATTERN, "PATTERN" — "C": pattern taken from port C
- SEL_MASK, "MASK" — "C": mask taken from port C
- AUTORESET_PATDET, "NO_RESET" — "RESET_MATCH" | "RESET_NOT_MATCH"

Ports:
- clk  in  1  clock, all state on rising edge
- RSTP  in  1  reset, asynchronous, active-high; clears all registers
- CEP  in  1  clock enable for the P, carry, multsign and flag registers
- ALU_OUT  in  48  ALU result
- CARRYOUT_ALU  in  4  ALU carry-outs
- MULTSIGN_ALU  in  1  multiplier sign from the ALU
- C  in  48  C operand, used as pattern and/or mask source
- P  out  48  result
- PCOUT  out  48  cascade copy of P
- CARRYOUT  out  4  carry-outs
- CARRYCASCOUT  out  1  CARRYOUT[3] cascade
- MULTSIGNOUT  out  1  multsign cascade
- PATTERNDETECT  out  1  result matches pattern under mask
- PATTERNBDETECT  out  1  result matches ~pattern under mask
- OVERFLOW  out  1  overflow detected
- UNDERFLOW  out  1  underflow detected

## Operation
- Select: pat = (SEL_PATTERN=="C") ? C : PATTERN; msk = (SEL_MASK=="C") ? C : MASK.
- Compare (combinational, on ALU_OUT):
  - pd_c = &((ALU_OUT ~^ pat) | msk)
  - pbd_c = &((ALU_OUT ~^ ~pat) | msk)
- PREG=1, at the rising edge, in priority order:
  - RSTP=1 (asynchronous): P, CARRYOUT, MULTSIGNOUT, PATTERNDETECT, PATTERNBDETECT, pd_past and pbd_past all go to 0.
  - Auto-reset condition true: P and CARRYOUT are cleared. This happens regardless of CEP. Flag registers and past registers update normally if CEP=1.
  - Otherwise, with CEP=1:
    - P<=ALU_OUT, CARRYOUT<=CARRYOUT_ALU, MULTSIGNOUT<=MULTSIGN_ALU
    - PATTERNDETECT<=pd_c, PATTERNBDETECT<=pbd_c
    - pd_past<=PATTERNDETECT, pbd_past<=PATTERNBDETECT
  - CEP=0 and no auto-reset: all registers hold.
- Auto-reset condition:
  - "RESET_MATCH": registered PATTERNDETECT=1.
  - "RESET_NOT_MATCH": pd_past=1 and PATTERNDETECT=0.
  - Ignored when USE_PATTERN_DETECT!="PATDET".
- Flags (combinational from registers, PREG=1 and PATDET only):
  - OVERFLOW = pd_past & ~PATTERNDETECT & ~PATTERNBDETECT
  - UNDERFLOW = pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT
- PREG=0:
  - P=ALU_OUT, CARRYOUT=CARRYOUT_ALU, MULTSIGNOUT=MULTSIGN_ALU.
  - PATTERNDETECT=pd_c, PATTERNBDETECT=pbd_c (when PATDET).
  - OVERFLOW and UNDERFLOW tied 0; auto-reset inactive; CEP and RSTP have no effect.
- Always: PCOUT=P, CARRYCASCOUT=CARRYOUT[3].
- With USE_PATTERN_DETECT!="PATDET": all four flags are 0 and the past registers are held at 0.

## Timing
- Reset value of every output is 0; RSTP acts immediately, without waiting for a clock edge.
- PREG=1: ALU_OUT to P, PCOUT and the flags takes 1 cycle. OVERFLOW/UNDERFLOW are valid the same cycle as the registered flags, using the previous-cycle history.
- PREG=0: 0-cycle latency.
- Auto-reset clears P at the edge after PATTERNDETECT is seen high ("RESET_MATCH"), so P is 0 for one cycle minimum.
- RSTP and CEP asserted together: reset wins. RSTP deasserted mid-operation: the history starts fresh, so no OVERFLOW is possible on the first enabled cycle.

## Test plan
- Reset/latency, PREG=1: RSTP pulse -> all outputs 0. Then ALU_OUT=48'h1234 with CEP=1 -> P=PCOUT=48'h1234 one cycle later; CEP=0 with a new ALU_OUT -> P holds 48'h1234.
- Masked detect: PATTERN=0, MASK=48'h0000_0000_00FF, PATDET.
  - ALU_OUT=48'h0000_0000_00AB -> PATTERNDETECT=1.
  - ALU_OUT=48'hFFFF_FFFF_FF12 -> PATTERNBDETECT=1.
  - ALU_OUT=48'h100 -> both flags 0.
- Overflow/underflow (same PATTERN and MASK):
  - Sequence 48'h7F then 48'h100 -> OVERFLOW=1 on the second registered cycle, UNDERFLOW=0.
  - Sequence 48'hFFFF_FFFF_FF80 then 48'hFFFF_FFFF_FEFF -> UNDERFLOW=1.
- Auto-reset "RESET_MATCH": PATTERN=48'h10, MASK=0.
  - ALU_OUT=48'h10 -> PATTERNDETECT=1 -> next edge P=0 even with CEP=0.
  - "RESET_NOT_MATCH": 48'h10 then 48'h11 -> P cleared one edge after the mismatch registers.
- C-sourced pattern: SEL_PATTERN="C", C=48'hABC, MASK=0.
  - ALU_OUT=48'hABC -> PATTERNDETECT=1; change C to 48'hABD -> 0 next cycle.
  - PREG=0 variant: flags follow ALU_OUT combinationally; OVERFLOW stays 0.
- Cascade/carry: CARRYOUT_ALU=4'b1000, MULTSIGN_ALU=1 -> CARRYOUT=4'b1000, CARRYCASCOUT=1, MULTSIGNOUT=1 after 1 cycle. Assert RSTP mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/p_out_stage.sv
// ---------------------------------------------------------------------------
// p_out_stage
//
// Output end of the DSP slice datapath. Takes the 48-bit ALU result,
// optionally registers it as P, drives the P / carry / multsign cascade
// outputs and runs the pattern detector (match, inverse match, overflow,
// underflow), including optional auto-reset of the P register.
//
// Ports:
//   clk             clock, all state on rising edge
//   RSTP            asynchronous active-high reset of every register
//   CEP             clock enable for P, carry, multsign and flag registers
//   ALU_OUT[47:0]   ALU result
//   CARRYOUT_ALU[3:0] ALU carry-outs
//   MULTSIGN_ALU    multiplier sign from the ALU
//   C[47:0]         operand used as dynamic pattern and/or mask
//   P[47:0]         result
//   PCOUT[47:0]     cascade copy of P
//   CARRYOUT[3:0]   carry-outs
//   CARRYCASCOUT    cascade of CARRYOUT[3]
//   MULTSIGNOUT     multsign cascade
//   PATTERNDETECT   result matches pattern under mask
//   PATTERNBDETECT  result matches inverted pattern under mask
//   OVERFLOW        match in previous cycle, neither match now
//   UNDERFLOW       inverse match in previous cycle, neither match now
// ---------------------------------------------------------------------------
module p_out_stage #(
    parameter int        PREG               = 1,
    parameter string     USE_PATTERN_DETECT = "NO_PATDET",
    parameter logic [47:0] PATTERN          = 48'h0,
    parameter logic [47:0] MASK             = 48'h3FFF_FFFF_FFFF,
    parameter string     SEL_PATTERN        = "PATTERN",
    parameter string     SEL_MASK           = "MASK",
    parameter string     AUTORESET_PATDET   = "NO_RESET"
) (
    input  logic        clk,
    input  logic        RSTP,
    input  logic        CEP,
    input  logic [47:0] ALU_OUT,
    input  logic [3:0]  CARRYOUT_ALU,
    input  logic        MULTSIGN_ALU,
    input  logic [47:0] C,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic [3:0]  CARRYOUT,
    output logic        CARRYCASCOUT,
    output logic        MULTSIGNOUT,
    output logic        PATTERNDETECT,
    output logic        PATTERNBDETECT,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam bit USE_PREG      = (PREG == 1);
    localparam bit PATDET_EN     = (USE_PATTERN_DETECT == "PATDET");
    localparam bit PAT_FROM_C    = (SEL_PATTERN == "C");
    localparam bit MSK_FROM_C    = (SEL_MASK == "C");
    localparam bit AR_MATCH      = (AUTORESET_PATDET == "RESET_MATCH");
    localparam bit AR_NOT_MATCH  = (AUTORESET_PATDET == "RESET_NOT_MATCH");

    logic [47:0] pat;
    logic [47:0] msk;
    logic        pd_c;
    logic        pbd_c;
    logic        auto_reset;

    logic [47:0] p_q, p_d;
    logic [3:0]  carry_q, carry_d;
    logic        multsign_q, multsign_d;
    logic        pd_q, pd_d;
    logic        pbd_q, pbd_d;
    logic        pd_past_q, pd_past_d;
    logic        pbd_past_q, pbd_past_d;

    // Masked compare of the unregistered ALU result. A mask bit of 1 forces
    // that bit position to count as matching. With the detector disabled
    // both results are forced low, which also keeps every flag and history
    // register at 0.
    always_comb begin
        pat   = PAT_FROM_C ? C : PATTERN;
        msk   = MSK_FROM_C ? C : MASK;
        pd_c  = PATDET_EN & (&((ALU_OUT ~^ pat)  | msk));
        pbd_c = PATDET_EN & (&((ALU_OUT ~^ ~pat) | msk));
    end

    // Auto-reset looks only at registered flags, so P is cleared one edge
    // after the triggering condition becomes visible on the outputs.
    always_comb begin
        auto_reset = 1'b0;
        if (USE_PREG && PATDET_EN) begin
            if (AR_MATCH) begin
                auto_reset = pd_q;
            end else if (AR_NOT_MATCH) begin
                auto_reset = pd_past_q & ~pd_q;
            end
        end
    end

    // Next-state: CEP loads everything; auto-reset then overrides only P and
    // the carry-outs, and does so even when CEP is low.
    always_comb begin
        p_d        = p_q;
        carry_d    = carry_q;
        multsign_d = multsign_q;
        pd_d       = pd_q;
        pbd_d      = pbd_q;
        pd_past_d  = pd_past_q;
        pbd_past_d = pbd_past_q;
        if (CEP) begin
            p_d        = ALU_OUT;
            carry_d    = CARRYOUT_ALU;
            multsign_d = MULTSIGN_ALU;
            pd_d       = pd_c;
            pbd_d      = pbd_c;
            pd_past_d  = pd_q;
            pbd_past_d = pbd_q;
        end
        if (auto_reset) begin
            p_d     = 48'h0;
            carry_d = 4'h0;
        end
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge clk or posedge RSTP) begin
        if (RSTP) begin
            p_q        <= 48'h0;
            carry_q    <= 4'h0;
            multsign_q <= 1'b0;
            pd_q       <= 1'b0;
            pbd_q      <= 1'b0;
            pd_past_q  <= 1'b0;
            pbd_past_q <= 1'b0;
        end else begin
            p_q        <= p_d;
            carry_q    <= carry_d;
            multsign_q <= multsign_d;
            pd_q       <= pd_d;
            pbd_q      <= pbd_d;
            pd_past_q  <= pd_past_d;
            pbd_past_q <= pbd_past_d;
        end
    end

    // Output selection. Without the P register the stage is a pure wire
    // path and overflow/underflow have no history to work from.
    always_comb begin
        if (USE_PREG) begin
            P              = p_q;
            CARRYOUT       = carry_q;
            MULTSIGNOUT    = multsign_q;
            PATTERNDETECT  = pd_q;
            PATTERNBDETECT = pbd_q;
            OVERFLOW       = PATDET_EN & pd_past_q  & ~pd_q & ~pbd_q;
            UNDERFLOW      = PATDET_EN & pbd_past_q & ~pd_q & ~pbd_q;
        end else begin
            P              = ALU_OUT;
            CARRYOUT       = CARRYOUT_ALU;
            MULTSIGNOUT    = MULTSIGN_ALU;
            PATTERNDETECT  = pd_c;
            PATTERNBDETECT = pbd_c;
            OVERFLOW       = 1'b0;
            UNDERFLOW      = 1'b0;
        end
        PCOUT        = P;
        CARRYCASCOUT = CARRYOUT[3];
    end

endmodule

// File: tb/tb_p_out_stage.sv
// ---------------------------------------------------------------------------
// tb_p_out_stage
//
// Five configurations of p_out_stage share one stimulus stream:
//   0: PREG=1, detector on, PATTERN=0, MASK=0xFF
//   1: PREG=1, RESET_MATCH,     PATTERN=0x10, MASK=0
//   2: PREG=1, RESET_NOT_MATCH, PATTERN=0x10, MASK=0
//   3: PREG=1, pattern from C, MASK=0
//   4: PREG=0, pattern from C, MASK=0
// Expected values are queued when stimulus is applied and popped when the
// outputs are sampled, one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_p_out_stage;

    localparam int NI = 5;
    localparam int F_P = 0, F_PCOUT = 1, F_CO = 2, F_CASC = 3, F_MS = 4,
                   F_PD = 5, F_PBD = 6, F_OV = 7, F_UN = 8;

    typedef struct {
        string       tag;
        int          inst;
        int          field;
        logic [47:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        RSTP;
    logic        CEP;
    logic [47:0] ALU_OUT;
    logic [3:0]  CARRYOUT_ALU;
    logic        MULTSIGN_ALU;
    logic [47:0] C;

    logic [47:0] p_o     [NI];
    logic [47:0] pcout_o [NI];
    logic [3:0]  co_o    [NI];
    logic        casc_o  [NI];
    logic        ms_o    [NI];
    logic        pd_o    [NI];
    logic        pbd_o   [NI];
    logic        ov_o    [NI];
    logic        un_o    [NI];

    exp_t sb[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    p_out_stage #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h0),
                  .MASK(48'h0000_0000_00FF)) u_det (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT),
        .CARRYOUT_ALU(CARRYOUT_ALU), .MULTSIGN_ALU(MULTSIGN_ALU), .C(C),
        .P(p_o[0]), .PCOUT(pcout_o[0]), .CARRYOUT(co_o[0]),
        .CARRYCASCOUT(casc_o[0]), .MULTSIGNOUT(ms_o[0]),
        .PATTERNDETECT(pd_o[0]), .PATTERNBDETECT(pbd_o[0]),
        .OVERFLOW(ov_o[0]), .UNDERFLOW(un_o[0]));

    p_out_stage #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h10),
                  .MASK(48'h0), .AUTORESET_PATDET("RESET_MATCH")) u_rm (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT),
        .CARRYOUT_ALU(CARRYOUT_ALU), .MULTSIGN_ALU(MULTSIGN_ALU), .C(C),
        .P(p_o[1]), .PCOUT(pcout_o[1]), .CARRYOUT(co_o[1]),
        .CARRYCASCOUT(casc_o[1]), .MULTSIGNOUT(ms_o[1]),
        .PATTERNDETECT(pd_o[1]), .PATTERNBDETECT(pbd_o[1]),
        .OVERFLOW(ov_o[1]), .UNDERFLOW(un_o[1]));

    p_out_stage #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .PATTERN(48'h10),
                  .MASK(48'h0), .AUTORESET_PATDET("RESET_NOT_MATCH")) u_rnm (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT),
        .CARRYOUT_ALU(CARRYOUT_ALU), .MULTSIGN_ALU(MULTSIGN_ALU), .C(C),
        .P(p_o[2]), .PCOUT(pcout_o[2]), .CARRYOUT(co_o[2]),
        .CARRYCASCOUT(casc_o[2]), .MULTSIGNOUT(ms_o[2]),
        .PATTERNDETECT(pd_o[2]), .PATTERNBDETECT(pbd_o[2]),
        .OVERFLOW(ov_o[2]), .UNDERFLOW(un_o[2]));

    p_out_stage #(.PREG(1), .USE_PATTERN_DETECT("PATDET"), .SEL_PATTERN("C"),
                  .MASK(48'h0)) u_csel (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT),
        .CARRYOUT_ALU(CARRYOUT_ALU), .MULTSIGN_ALU(MULTSIGN_ALU), .C(C),
        .P(p_o[3]), .PCOUT(pcout_o[3]), .CARRYOUT(co_o[3]),
        .CARRYCASCOUT(casc_o[3]), .MULTSIGNOUT(ms_o[3]),
        .PATTERNDETECT(pd_o[3]), .PATTERNBDETECT(pbd_o[3]),
        .OVERFLOW(ov_o[3]), .UNDERFLOW(un_o[3]));

    p_out_stage #(.PREG(0), .USE_PATTERN_DETECT("PATDET"), .SEL_PATTERN("C"),
                  .MASK(48'h0)) u_comb (
        .clk(clk), .RSTP(RSTP), .CEP(CEP), .ALU_OUT(ALU_OUT),
        .CARRYOUT_ALU(CARRYOUT_ALU), .MULTSIGN_ALU(MULTSIGN_ALU), .C(C),
        .P(p_o[4]), .PCOUT(pcout_o[4]), .CARRYOUT(co_o[4]),
        .CARRYCASCOUT(casc_o[4]), .MULTSIGNOUT(ms_o[4]),
        .PATTERNDETECT(pd_o[4]), .PATTERNBDETECT(pbd_o[4]),
        .OVERFLOW(ov_o[4]), .UNDERFLOW(un_o[4]));

    // Reads one output field of one instance, zero-extended to 48 bits.
    function automatic logic [47:0] observe(input int inst, input int field);
        case (field)
            F_P:     return p_o[inst];
            F_PCOUT: return pcout_o[inst];
            F_CO:    return {44'h0, co_o[inst]};
            F_CASC:  return {47'h0, casc_o[inst]};
            F_MS:    return {47'h0, ms_o[inst]};
            F_PD:    return {47'h0, pd_o[inst]};
            F_PBD:   return {47'h0, pbd_o[inst]};
            F_OV:    return {47'h0, ov_o[inst]};
            default: return {47'h0, un_o[inst]};
        endcase
    endfunction

    task automatic applyStimulus(input logic [47:0] alu, input logic [47:0] c,
                                 input logic cep, input logic [3:0] carry,
                                 input logic ms);
        ALU_OUT      = alu;
        C            = c;
        CEP          = cep;
        CARRYOUT_ALU = carry;
        MULTSIGN_ALU = ms;
    endtask

    task automatic expectVal(input string tag, input int inst, input int field,
                             input logic [47:0] value);
        exp_t e;
        e.tag   = tag;
        e.inst  = inst;
        e.field = field;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [47:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.inst, e.field);
            testsRun++;
            assert (obs === e.value) else begin
                testsFailed++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic resetPulse();
        RSTP = 1'b1;
        #1;
        RSTP = 1'b0;
    endtask

    // Directed sequence: reset/latency, masked detect, overflow/underflow,
    // cascade and mid-stream reset, auto-reset modes, C-sourced pattern.
    initial begin
        RSTP = 1'b1;
        applyStimulus(48'h1234, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("rst_p",     0, F_P, 48'h0);
        expectVal("rst_pcout", 0, F_PCOUT, 48'h0);
        expectVal("rst_co",    0, F_CO, 48'h0);
        expectVal("rst_ms",    0, F_MS, 48'h0);
        expectVal("rst_pd",    0, F_PD, 48'h0);
        expectVal("rst_ov",    0, F_OV, 48'h0);
        checkOutput();
        RSTP = 1'b0;

        applyStimulus(48'h1234, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("lat_p",     0, F_P, 48'h1234);
        expectVal("lat_pcout", 0, F_PCOUT, 48'h1234);
        expectVal("lat_pd",    0, F_PD, 48'h0);
        checkOutput();

        applyStimulus(48'h5678, 48'h0, 1'b0, 4'h0, 1'b0);
        tick();
        expectVal("hold_p", 0, F_P, 48'h1234);
        checkOutput();

        applyStimulus(48'h0000_0000_00AB, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("det_pd",  0, F_PD, 48'h1);
        expectVal("det_pbd", 0, F_PBD, 48'h0);
        checkOutput();

        applyStimulus(48'hFFFF_FFFF_FF12, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("inv_pd",  0, F_PD, 48'h0);
        expectVal("inv_pbd", 0, F_PBD, 48'h1);
        expectVal("inv_ov",  0, F_OV, 48'h0);
        checkOutput();

        applyStimulus(48'h100, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("none_pd",  0, F_PD, 48'h0);
        expectVal("none_pbd", 0, F_PBD, 48'h0);
        expectVal("none_un",  0, F_UN, 48'h1);
        checkOutput();

        applyStimulus(48'h7F, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("ov1_pd", 0, F_PD, 48'h1);
        expectVal("ov1_ov", 0, F_OV, 48'h0);
        checkOutput();

        applyStimulus(48'h100, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("ov2_ov", 0, F_OV, 48'h1);
        expectVal("ov2_un", 0, F_UN, 48'h0);
        checkOutput();

        applyStimulus(48'hFFFF_FFFF_FF80, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("un1_pbd", 0, F_PBD, 48'h1);
        expectVal("un1_un",  0, F_UN, 48'h0);
        checkOutput();

        applyStimulus(48'hFFFF_FFFF_FEFF, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("un2_un", 0, F_UN, 48'h1);
        expectVal("un2_ov", 0, F_OV, 48'h0);
        checkOutput();

        applyStimulus(48'h7F, 48'h0, 1'b1, 4'b1000, 1'b1);
        tick();
        expectVal("cas_co",   0, F_CO, 48'h8);
        expectVal("cas_casc", 0, F_CASC, 48'h1);
        expectVal("cas_ms",   0, F_MS, 48'h1);
        expectVal("cas_pd",   0, F_PD, 48'h1);
        checkOutput();

        RSTP = 1'b1;
        #1;
        expectVal("mid_p",    0, F_P, 48'h0);
        expectVal("mid_co",   0, F_CO, 48'h0);
        expectVal("mid_casc", 0, F_CASC, 48'h0);
        expectVal("mid_ms",   0, F_MS, 48'h0);
        expectVal("mid_pd",   0, F_PD, 48'h0);
        checkOutput();
        RSTP = 1'b0;

        applyStimulus(48'h100, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("fresh_ov", 0, F_OV, 48'h0);
        expectVal("fresh_p",  0, F_P, 48'h100);
        checkOutput();

        resetPulse();
        applyStimulus(48'h10, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("rm_load",  1, F_P, 48'h10);
        expectVal("rm_pd",    1, F_PD, 48'h1);
        expectVal("rnm_load", 2, F_P, 48'h10);
        checkOutput();

        applyStimulus(48'h22, 48'h0, 1'b0, 4'h0, 1'b0);
        tick();
        expectVal("rm_clr",   1, F_P, 48'h0);
        expectVal("rnm_hold", 2, F_P, 48'h10);
        checkOutput();

        applyStimulus(48'h11, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("rm_again", 1, F_P, 48'h0);
        expectVal("rnm_mis",  2, F_P, 48'h11);
        checkOutput();

        applyStimulus(48'h33, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("rm_rel",  1, F_P, 48'h33);
        expectVal("rnm_clr", 2, F_P, 48'h0);
        checkOutput();

        applyStimulus(48'h44, 48'h0, 1'b1, 4'h0, 1'b0);
        tick();
        expectVal("rnm_rel", 2, F_P, 48'h44);
        checkOutput();

        resetPulse();
        applyStimulus(48'hABC, 48'hABC, 1'b1, 4'h0, 1'b0);
        #1;
        expectVal("cb_pd_now", 4, F_PD, 48'h1);
        expectVal("cb_p_now",  4, F_P, 48'hABC);
        expectVal("cs_pd_pre", 3, F_PD, 48'h0);
        checkOutput();
        tick();
        expectVal("cs_pd", 3, F_PD, 48'h1);
        checkOutput();

        applyStimulus(48'hABC, 48'hABD, 1'b1, 4'h0, 1'b0);
        #1;
        expectVal("cb_pd_off", 4, F_PD, 48'h0);
        expectVal("cs_pd_old", 3, F_PD, 48'h1);
        expectVal("cb_ov",     4, F_OV, 48'h0);
        checkOutput();
        tick();
        expectVal("cs_pd_off", 3, F_PD, 48'h0);
        checkOutput();

        applyStimulus(~48'hABD, 48'hABD, 1'b1, 4'h0, 1'b0);
        #1;
        expectVal("cb_pbd", 4, F_PBD, 48'h1);
        expectVal("cb_un",  4, F_UN, 48'h0);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
